// File: rtl/lsu_mem_responder.sv
// Word-organised data RAM behind the LSU: accepts one request at a time, applies
// byte-masked writes or returns a full word after LATENCY wait states.
module lsu_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             commit;
    logic             ram_wr;

    logic [31:0]      ram [DEPTH];

    // Only the word-index bits of the address take part in decoding.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    idx_d   = addr_i[IDX_W+1:2];
                    we_d    = write_enable_i;
                    be_d    = byte_enable_i;
                    wdata_d = write_data_i;
                    if (LATENCY == 0) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = LAT_CNT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The *_d copies equal the captured request both on the capture edge
        // (zero latency) and later, so the commit path uses them uniformly.
        if (commit) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if (!we_d) begin
                rdata_d = ram[idx_d];
            end
        end

        ram_wr = commit && we_d && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // RAM contents survive reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_d[k]) begin
                    ram[idx_d][8*k +: 8] <= wdata_d[8*k +: 8];
                end
            end
        end
    end

    assign read_data_o = rdata_q;
    assign ready_o     = ready_q;

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU data interface.
- Receives the LSU's request: req, write-enable, byte-enable, address and write-data. Returns read data and a single-cycle ready after a configurable number of wait states.
- Holds a word-organised data RAM and applies byte-masked writes.
- Serves as the data memory behind the core's LSU. Its programmable latency exercises the stall path through the LSU.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two, ≥ 4).
- LATENCY, 2, wait-state cycles between acceptance and the ready pulse (0..15).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- mem_req_i  input  1  request from the LSU; held high until ready_o is seen.
- write_enable_i  input  1  1 = write, 0 = read.
- byte_enable_i  input  4  write byte mask; bit k covers data bits [8k+7:8k].
- addr_i  input  32  byte address.
- write_data_i  input  32  write data, already lane-aligned by the LSU.
- read_data_o  output  32  full word read data; valid while ready_o=1 on a read.
- ready_o  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: clk_i / rst_i.
- Reset values:
  - state = IDLE, wait counter = 0, ready_o = 0, read_data_o = 32'h0.
  - RAM contents are not reset.
- Addressing:
  - word index = addr_i[$clog2(DEPTH)+1:2].
  - addr_i[1:0] and all bits above the index are ignored, so addresses alias modulo DEPTH*4.
- States: IDLE, WAIT, RESP. The state is registered.
- IDLE:
  - ready_o = 0.
  - If mem_req_i=1 at an edge, capture addr_i, write_enable_i, byte_enable_i and write_data_i into internal registers.
  - If LATENCY=0, go to RESP. Otherwise load counter = LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where counter = 1, go to RESP.
  - Inputs are ignored; only the captured copies are used. Deasserting mem_req_i does not abort the transfer.
- Transition into RESP (the same edge that enters RESP):
  - Write: for each k with captured be[k]=1, update byte k of RAM[index]. read_data_o keeps its previous value.
  - Read: read_data_o <= RAM[index].
  - ready_o <= 1 (registered).
- RESP:
  - ready_o = 1 for exactly one cycle.
  - The next edge always returns to IDLE and clears ready_o. read_data_o holds its value until the next read response.
  - A request present during RESP is not accepted. Because the LSU holds req, that request is accepted in the following IDLE cycle.
- Latency:
  - Request first sampled high in IDLE at cycle N → ready_o high in cycle N+LATENCY+1.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Write with byte_enable_i = 4'b0000: RAM is unchanged; ready_o still pulses.
- Read after write to the same word returns the new data. The write commits before the later read's RESP edge.
- Reset mid-operation:
  - rst_i=1 in WAIT or RESP returns to IDLE with ready_o = 0.
  - A write whose RESP edge coincides with reset is NOT committed; reset wins over every transition.
  - An aborted transfer produces no ready pulse.
- Counter width: 4 bits; no wrap, because it is only loaded with LATENCY ≥ 1.

Test Plan:
- Reset then read: rst_i high 2 cycles, check ready_o=0 and read_data_o=0 → then full write 0xDEADBEEF to 0x10 (be=1111), read 0x10 → read_data_o=0xDEADBEEF with ready_o high exactly 3 cycles after req (LATENCY=2), 1 cycle wide.
- Byte masking: RAM[0x20]=0x11223344, write 0xAABBCCDD with be=0110 → read returns 0x11BBCC44; write with be=0000 → unchanged.
- Aliasing and low bits: DEPTH=1024, write 0x55 (be=0001) to 0x1003, read 0x0000 → byte 0 = 0x55; read 0x1000 → same word.
- Back-to-back held req: keep req high across two reads of 0x10 and 0x14 → ready pulses at N+3 and N+7, each with the correct word; no request is accepted in RESP.
- LATENCY=0 build: read request in cycle N → ready_o in N+1; request held continuously → ready pulses every 2 cycles.
- Reset mid-write: write 0xFFFFFFFF to 0x30 (old 0x0), assert rst_i on the cycle WAIT would go to RESP → no ready_o pulse; subsequent read of 0x30 returns 0x0.
